axi_cache_wb_write: RTL and testbench
=====================================

// Module: axi_cache_wb_write
// PURPOSE
//  AXI3 write-channel master (AW/W/B) for the myCPU bus interface; write-side counterpart of the read merge.
//  Accepts one request at a time: a 16-word D-cache line writeback (INCR burst) or one uncached store (single beat).
//  Latches the request, then sequences AW -> W beats -> B; reports completion to the cache/LSU.
// PARAMETERS
//  LINE_WORDS  16     words per cache line; burst length, awlen = LINE_WORDS-1
//  WR_ID       4'd1   value driven on awid and wid
// PORTS
//  aclk        in   1    clock
//  aresetn     in   1    async active-low reset
//  wr_req      in   1    request valid
//  wr_ready    out  1    block idle, can accept request
//  wr_burst    in   1    1 = line writeback, 0 = single uncached store
//  wr_addr     in   32   byte address (line-aligned when wr_burst=1)
//  wr_strb     in   4    byte strobes for single store (ignored for bursts)
//  wr_line     in   32*LINE_WORDS  line data, word i at [32i+31:32i]; single store uses word 0
//  wr_done     out  1    1-cycle pulse: B response received
//  wr_err      out  1    valid with wr_done: bresp != OKAY
//  awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1
//  awready     in   1
//  wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1
//  wready      in   1
//  bid         in   4    ignored
//  bresp       in   2
//  bvalid      in   1
//  bready      out  1
// BEHAVIOUR
//  Reset (async, aresetn=0): state IDLE; awvalid, wvalid, wlast, bready, wr_done, wr_err, wr_ready = 0; beat cnt = 0.
//  wr_ready is registered: 1 from first edge after reset release while IDLE; 0 in all other states.
//  Constants: awsize=3'b010; awlock=0; awcache=0; awprot=0; awid=wid=WR_ID.
//  awlen = burst ? LINE_WORDS-1 : 0; awburst = burst ? 2'b01 (INCR) : 2'b00.
//  IDLE: wr_req & wr_ready at edge N -> latch addr, burst, strb, whole wr_line; wr_ready=0, awvalid=1 from N+1.
//  AW: awvalid, awaddr, awlen, awburst stable until awvalid & awready; then awvalid=0, wvalid=1 next cycle, cnt=0.
//  W: wdata = latched word[cnt]; wstrb = burst ? 4'hf : latched strb; wlast = (cnt == awlen).
//   Each wvalid & wready edge: cnt+1; data/strb/wlast hold while wready=0.
//   Handshake with wlast=1 -> wvalid=0, bready=1 next cycle.
//  B: bready=1 until bvalid; on bvalid & bready edge M -> IDLE; wr_done=1 for cycle M+1 only; wr_ready=1 at M+1.
//  No AW/W overlap: W never driven before AW handshake; exactly awlen+1 beats per request.
//  wr_req while busy ignored (no queueing); requester holds until wr_ready.
//  Best-case single store: accept N, AW N+1, W N+2, B N+3, wr_done N+4.
//  Reset mid-operation: return to IDLE immediately; transaction abandoned; no wr_done pulse.
//  cnt width clog2(LINE_WORDS); no wrap inside a burst (saturates at awlen).
// CONFIGURATION
//  AXI_WB_BRESP_CHECK_EN defined: wr_err = (bresp != 2'b00), registered with wr_done, 0 otherwise.
//  Not defined: wr_err tied 0; bresp ignored; port retained.
// TESTING
//  Reset: aresetn=0 -> all outputs 0; release -> wr_ready=1 next edge, awvalid=0.
//  Single store addr=0xBFAF_F010 strb=4'b0011 word0=0x1234_5678, ready always 1 ->
//   awlen=0, awburst=00, one beat wdata=0x1234_5678 wstrb=0011 wlast=1, wr_done at N+4.
//  Line writeback addr=0x0000_1000, word i=0xA000_0000+i, wready toggling 1/0 ->
//   awlen=0x0F, awburst=01, 16 beats 0xA000_0000..0xA000_000F in order, wlast only on beat 15.
//  awready held 0 for 5 cycles -> awvalid and awaddr stable all 5 cycles; wvalid stays 0 until after handshake.
//  With AXI_WB_BRESP_CHECK_EN, bresp=2'b10 -> wr_done=1 and wr_err=1 same cycle; without macro wr_err=0.
//  wr_req during burst ignored (wr_ready=0); aresetn=0 at beat 7 -> wvalid=0 immediately, IDLE, no wr_done.

Source files
------------

// File: rtl/axi_cache_wb_write_if.sv
// AXI3 write-address, write-data and write-response channels between the
// cache writeback master and the bus.
interface axi_cache_wb_write_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_cache_wb_write.sv
// AXI3 write master: one line writeback (INCR burst) or one uncached store per request, AW -> W -> B.
// Define AXI_WB_BRESP_CHECK_EN to report bresp != OKAY on wr_err; otherwise wr_err is tied low.
module axi_cache_wb_write #(
    parameter int unsigned LINE_WORDS = 16,
    parameter logic [3:0]  WR_ID      = 4'd1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       wr_req,
    output logic                       wr_ready,
    input  logic                       wr_burst,
    input  logic [31:0]                wr_addr,
    input  logic [3:0]                 wr_strb,
    input  logic [32*LINE_WORDS-1:0]   wr_line,
    output logic                       wr_done,
    output logic                       wr_err,
    axi_cache_wb_write_if.master       axi
);
    localparam int unsigned CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_burst;
    logic [31:0]                  r_addr;
    logic [3:0]                   r_strb;
    logic [LINE_WORDS-1:0][31:0]  r_line;
    logic [CW-1:0]                r_cnt;
    logic                         r_wr_ready;
    logic                         r_wr_done;
    logic                         r_wr_err;
    logic [CW-1:0]                w_last_idx;
    logic                         w_at_last;
    logic                         w_accept;
    logic                         w_b_hs;

    assign w_last_idx = r_burst ? CW'(LINE_WORDS - 1) : '0;
    assign w_at_last  = (r_cnt == w_last_idx);
    assign w_accept   = (r_state == S_IDLE) && wr_req && r_wr_ready;
    assign w_b_hs     = (r_state == S_B) && axi.bvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)                 w_next = S_AW;
            S_AW:   if (axi.awready)              w_next = S_W;
            S_W:    if (axi.wready && w_at_last)  w_next = S_B;
            S_B:    if (axi.bvalid)               w_next = S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    always_comb begin
        axi.awid    = WR_ID;
        axi.awaddr  = r_addr;
        axi.awlen   = r_burst ? 8'(LINE_WORDS - 1) : 8'd0;
        axi.awsize  = 3'b010;
        axi.awburst = r_burst ? 2'b01 : 2'b00;
        axi.awlock  = '0;
        axi.awcache = '0;
        axi.awprot  = '0;
        axi.awvalid = (r_state == S_AW);
        axi.wid     = WR_ID;
        axi.wdata   = r_line[r_cnt];
        axi.wstrb   = r_burst ? 4'hf : r_strb;
        axi.wlast   = (r_state == S_W) && w_at_last;
        axi.wvalid  = (r_state == S_W);
        axi.bready  = (r_state == S_B);
    end

    // Request fields are captured whole so the requester may change them right after acceptance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_burst    <= 1'b0;
            r_addr     <= '0;
            r_strb     <= '0;
            r_line     <= '0;
            r_cnt      <= '0;
            r_wr_ready <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_burst <= wr_burst;
                r_addr  <= wr_addr;
                r_strb  <= wr_strb;
                r_line  <= wr_line;
            end
            if ((r_state == S_AW) && axi.awready) begin
                r_cnt <= '0;
            end else if ((r_state == S_W) && axi.wready && !w_at_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_wr_ready <= (w_next == S_IDLE);
            r_wr_done  <= w_b_hs;
        end
    end

`ifdef AXI_WB_BRESP_CHECK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_b_hs && (axi.bresp != 2'b00);
        end
    end

    logic w_unused_b;
    assign w_unused_b = ^axi.bid;
`else
    assign r_wr_err = 1'b0;

    logic w_unused_b;
    assign w_unused_b = ^{axi.bid, axi.bresp};
`endif

    assign wr_ready = r_wr_ready;
    assign wr_done  = r_wr_done;
    assign wr_err   = r_wr_err;
endmodule

// File: tb/tb_axi_cache_wb_write.sv
// Bench for axi_cache_wb_write: table-driven transactions, hand-written reset/busy corners, and
// randomized requests checked against a beat-list reference model.
module tb_axi_cache_wb_write;
    localparam int unsigned LW = 16;
`ifdef AXI_WB_BRESP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic              wr_req = 1'b0;
    logic              wr_ready;
    logic              wr_burst = 1'b0;
    logic [31:0]       wr_addr = '0;
    logic [3:0]        wr_strb = '0;
    logic [32*LW-1:0]  wr_line = '0;
    logic              wr_done;
    logic              wr_err;

    axi_cache_wb_write_if axi ();

    axi_cache_wb_write #(.LINE_WORDS(LW), .WR_ID(4'd1)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_req   (wr_req),
        .wr_ready (wr_ready),
        .wr_burst (wr_burst),
        .wr_addr  (wr_addr),
        .wr_strb  (wr_strb),
        .wr_line  (wr_line),
        .wr_done  (wr_done),
        .wr_err   (wr_err),
        .axi      (axi)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        bit          last;
    } beat_t;

    beat_t exp_q[$];

    typedef struct {
        bit          burst;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] base;
        int          aw_dly;
        int          wmode;     // 0 wready always 1, 1 toggling, 2 random
        int          b_dly;
        logic [1:0]  bresp;
        bit          poke_busy;
        logic [7:0]  exp_awlen;
        logic [1:0]  exp_awburst;
        int          exp_beats;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference: the ordered list of W beats a request must produce.
    function automatic void model_request(input bit burst, input logic [3:0] strb,
                                          input logic [32*LW-1:0] line);
        int unsigned n;
        n = burst ? LW : 1;
        exp_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            beat_t b;
            b.data = line[32*i +: 32];
            b.strb = burst ? 4'hf : strb;
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic run_txn(input bit burst, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [32*LW-1:0] line, input int aw_dly, input int wmode,
                           input int b_dly, input logic [1:0] bresp, input bit poke_busy,
                           input logic [7:0] exp_awlen, input logic [1:0] exp_awburst,
                           input int exp_beats, input bit exp_err);
        int  guard;
        int  beat;
        bit  w;
        model_request(burst, strb, line);
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("idle_ready", wr_ready, 1);
        wr_req = 1'b1; wr_burst = burst; wr_addr = addr; wr_strb = strb; wr_line = line;
        tick();
        // Scramble the request inputs: the DUT must work from its latched copy.
        wr_req = 1'b0; wr_burst = ~burst; wr_addr = ~addr; wr_strb = ~strb; wr_line = ~line;
        check("ready_low_after_accept", wr_ready, 0);
        check("awvalid_after_accept", axi.awvalid, 1);
        check("awlen", axi.awlen, exp_awlen);
        check("awburst", axi.awburst, exp_awburst);
        check("awsize", axi.awsize, 3'b010);
        check("awid", axi.awid, 4'd1);
        check("aw_lock_cache_prot", {axi.awlock, axi.awcache, axi.awprot}, 0);
        for (int c = 0; c < aw_dly; c++) begin
            check("aw_hold_valid", axi.awvalid, 1);
            check("aw_hold_addr", axi.awaddr, addr);
            check("no_w_before_aw", axi.wvalid, 0);
            tick();
        end
        check("awaddr", axi.awaddr, addr);
        check("no_w_before_aw", axi.wvalid, 0);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        check("aw_drop", axi.awvalid, 0);
        check("w_start", axi.wvalid, 1);
        beat = 0;
        guard = 0;
        while (axi.wvalid === 1'b1 && guard < 200) begin
            case (wmode)
                0:       w = 1'b1;
                1:       w = (guard % 2 == 0);
                default: w = 1'($urandom_range(0, 1));
            endcase
            if (poke_busy) begin
                wr_req = 1'b1;
                check("busy_ready_low", wr_ready, 0);
            end
            if (beat < exp_q.size()) begin
                check("wdata", axi.wdata, exp_q[beat].data);
                check("wstrb", axi.wstrb, exp_q[beat].strb);
                check("wlast", axi.wlast, exp_q[beat].last);
                check("wid", axi.wid, 4'd1);
            end else begin
                check("extra_beat", beat, exp_q.size());
            end
            axi.wready = w;
            tick();
            axi.wready = 1'b0;
            if (w) beat++;
            guard++;
        end
        wr_req = 1'b0;
        check("beat_count", beat, exp_beats);
        check("bready_after_last", axi.bready, 1);
        for (int c = 0; c < b_dly; c++) begin
            check("b_wait_bready", axi.bready, 1);
            check("no_early_done", wr_done, 0);
            tick();
        end
        axi.bvalid = 1'b1; axi.bresp = bresp; axi.bid = 4'($urandom);
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        check("wr_done", wr_done, 1);
        check("wr_err", wr_err, exp_err);
        check("ready_back", wr_ready, 1);
        check("bready_drop", axi.bready, 0);
        tick();
        check("done_pulse", wr_done, 0);
        check("no_new_aw", axi.awvalid, 0);
    endtask

    function automatic vec_t mk(input bit burst, input logic [31:0] addr, input logic [3:0] strb,
                                input logic [31:0] base, input int aw_dly, input int wmode,
                                input int b_dly, input logic [1:0] bresp, input bit poke,
                                input logic [7:0] e_len, input logic [1:0] e_burst,
                                input int e_beats, input bit e_err);
        vec_t v;
        v.burst = burst; v.addr = addr; v.strb = strb; v.base = base;
        v.aw_dly = aw_dly; v.wmode = wmode; v.b_dly = b_dly; v.bresp = bresp; v.poke_busy = poke;
        v.exp_awlen = e_len; v.exp_awburst = e_burst; v.exp_beats = e_beats; v.exp_err = e_err;
        return v;
    endfunction

    initial begin
        vec_t             tbl[5];
        logic [32*LW-1:0] line;
        bit               rb;
        logic [31:0]      ra;
        logic [3:0]       rs;
        logic [1:0]       rr;

        tbl[0] = mk(1'b0, 32'hBFAF_F010, 4'b0011, 32'h1234_5678, 0, 0, 0, 2'b00, 1'b0, 8'h00, 2'b00, 1,  1'b0);
        tbl[1] = mk(1'b1, 32'h0000_1000, 4'b0000, 32'hA000_0000, 0, 1, 0, 2'b00, 1'b1, 8'h0F, 2'b01, 16, 1'b0);
        tbl[2] = mk(1'b0, 32'h8000_0004, 4'b1000, 32'hCAFE_0001, 5, 0, 0, 2'b10, 1'b0, 8'h00, 2'b00, 1,  CHECK_EN);
        tbl[3] = mk(1'b1, 32'h2000_0040, 4'b0101, 32'h5555_0000, 5, 0, 3, 2'b11, 1'b0, 8'h0F, 2'b01, 16, CHECK_EN);
        tbl[4] = mk(1'b0, 32'h0000_0008, 4'b1111, 32'hDEAD_BEEF, 1, 2, 2, 2'b01, 1'b0, 8'h00, 2'b00, 1,  CHECK_EN);

        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;

        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_wlast", axi.wlast, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_wr_ready", wr_ready, 0);
        aresetn = 1'b1;
        #1;
        check("rel_ready_before_edge", wr_ready, 0);
        tick();
        check("rel_ready", wr_ready, 1);
        check("rel_awvalid", axi.awvalid, 0);

        for (int t = 0; t < 5; t++) begin
            for (int unsigned i = 0; i < LW; i++)
                line[32*i +: 32] = tbl[t].burst ? tbl[t].base + i : (i == 0 ? tbl[t].base : ~(tbl[t].base + i));
            run_txn(tbl[t].burst, tbl[t].addr, tbl[t].strb, line, tbl[t].aw_dly, tbl[t].wmode,
                    tbl[t].b_dly, tbl[t].bresp, tbl[t].poke_busy, tbl[t].exp_awlen,
                    tbl[t].exp_awburst, tbl[t].exp_beats, tbl[t].exp_err);
        end

        // Reset in the middle of a line writeback, with beat 7 on the bus.
        for (int unsigned i = 0; i < LW; i++) line[32*i +: 32] = 32'h7700_0000 + i;
        wr_req = 1'b1; wr_burst = 1'b1; wr_addr = 32'h0000_3000; wr_line = line;
        tick();
        wr_req = 1'b0;
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready = 1'b1;
        repeat (7) tick();
        axi.wready = 1'b0;
        check("mid_wvalid_beat7", axi.wvalid, 1);
        check("mid_wdata_beat7", axi.wdata, 32'h7700_0007);
        aresetn = 1'b0;
        #1;
        check("mid_rst_wvalid", axi.wvalid, 0);
        check("mid_rst_wlast", axi.wlast, 0);
        check("mid_rst_bready", axi.bready, 0);
        check("mid_rst_awvalid", axi.awvalid, 0);
        check("mid_rst_ready", wr_ready, 0);
        tick();
        aresetn = 1'b1;
        tick();
        check("mid_rel_ready", wr_ready, 1);
        for (int c = 0; c < 5; c++) begin
            check("mid_no_done", wr_done, 0);
            check("mid_no_wvalid", axi.wvalid, 0);
            tick();
        end

        for (int t = 0; t < 25; t++) begin
            rb = 1'($urandom_range(0, 1));
            ra = $urandom;
            if (rb) ra[5:0] = '0; else ra[1:0] = '0;
            rs = 4'($urandom);
            rr = 2'($urandom);
            for (int unsigned i = 0; i < LW; i++) line[32*i +: 32] = $urandom;
            run_txn(rb, ra, rs, line, int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)), rr, 1'b0,
                    rb ? 8'(LW - 1) : 8'd0, rb ? 2'b01 : 2'b00, rb ? LW : 1, CHECK_EN && (rr != 2'b00));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
